// File: rtl/proc_pkg.sv
// Shared processor-side types and widths used by the data-RAM arbiter.
package proc_pkg;

  localparam int P_MEM_address = 8;
  localparam int P_PROC_data   = 8;

  typedef enum logic {M_CPU, M_EXT} master_t;
  typedef enum logic {UNLOCKED, LOCKED_M0} lock_t;

  // A zero MAX_WAIT still needs a one-bit counter to hold its (constant) value.
  function automatic int cnt_width(input int max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/arbiter_pamieci_danych_if.sv
// Bus bundle between the two RAM masters, the arbiter and the RAM instance.
interface arbiter_pamieci_danych_if #(
  parameter int AW       = proc_pkg::P_MEM_address,
  parameter int DW       = proc_pkg::P_PROC_data,
  parameter int MAX_WAIT = 4
) ();
  import proc_pkg::*;

  localparam int CW = cnt_width(MAX_WAIT);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_lock;
  logic          m0_gnt;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;

  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] wait_cnt;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output mem_we, mem_addr, mem_wdata, wait_cnt
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  mem_we, mem_addr, mem_wdata, wait_cnt
  );

endinterface

// File: rtl/arb_glodzenie.sv
// Saturating count of consecutive cycles master 1 has lost arbitration.
module arb_glodzenie #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  localparam logic [CW-1:0] SAT_VAL = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != SAT_VAL))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == SAT_VAL);

endmodule

// File: rtl/arbiter_pamieci_danych.sv
// Single-port data RAM arbiter: CPU priority, starvation force for master 1, CPU bus lock.
//   state     | meaning
//   UNLOCKED  | normal arbitration, starvation force active
//   LOCKED_M0 | CPU owns the bus for an atomic sequence; master 1 blocked
module arbiter_pamieci_danych
  import proc_pkg::*;
#(
  parameter int AW       = P_MEM_address,
  parameter int DW       = P_PROC_data,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  arbiter_pamieci_danych_if.slave  bus
);

  localparam int CW = cnt_width(MAX_WAIT);

  lock_t         lock_q, lock_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          locked;
  logic          sat;
  logic          gnt0, gnt1;
  logic [CW-1:0] wait_cnt;
  master_t       winner;
  logic          mem_we_w;
  logic [AW-1:0] mem_addr_w;
  logic [DW-1:0] mem_wdata_w;

  // Grants are held off during reset so nothing reaches the RAM.
  always_comb begin
    locked = (lock_q == LOCKED_M0);
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (rst) begin
      if (locked && bus.m0_req)
        gnt0 = 1'b1;
      else if (bus.m1_req && sat && !locked)
        gnt1 = 1'b1;
      else if (bus.m0_req)
        gnt0 = 1'b1;
      else if (bus.m1_req && !(locked && bus.m0_lock))
        gnt1 = 1'b1;
    end
  end

  always_comb begin
    winner      = gnt1 ? M_EXT : M_CPU;
    mem_we_w    = 1'b0;
    mem_addr_w  = '0;
    mem_wdata_w = '0;
    if (gnt0 || gnt1) begin
      case (winner)
        M_CPU: begin
          mem_we_w    = bus.m0_we;
          mem_addr_w  = bus.m0_addr;
          mem_wdata_w = bus.m0_wdata;
        end
        M_EXT: begin
          mem_we_w    = bus.m1_we;
          mem_addr_w  = bus.m1_addr;
          mem_wdata_w = bus.m1_wdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      UNLOCKED:  if (gnt0 && bus.m0_lock) lock_d = LOCKED_M0;
      LOCKED_M0: if (!bus.m0_lock)        lock_d = UNLOCKED;
      default:                            lock_d = UNLOCKED;
    endcase
    rv0_d   = gnt0 && !bus.m0_we;
    rv1_d   = gnt1 && !bus.m1_we;
    rdata_d = rdata_q;
    if (rv0_d || rv1_d)
      rdata_d = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q  <= UNLOCKED;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      lock_q  <= lock_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rdata_q <= rdata_d;
    end
  end

  arb_glodzenie #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_glodzenie (
    .clk (clk),
    .rst (rst),
    .inc (bus.m1_req && gnt0),
    .clr (gnt1 || !bus.m1_req),
    .cnt (wait_cnt),
    .sat (sat)
  );

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv0_q;
  assign bus.m1_rvalid = rv1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_we    = mem_we_w;
  assign bus.mem_addr  = mem_addr_w;
  assign bus.mem_wdata = mem_wdata_w;
  assign bus.wait_cnt  = wait_cnt;

endmodule

// File: tb/tb_arbiter_pamieci_danych.sv
// Bench for arbiter_pamieci_danych: explicit grant expectations, read-return scoreboard.
module tb_arbiter_pamieci_danych;
  import proc_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arbiter_pamieci_danych_if #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) bus ();

  arbiter_pamieci_danych #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];

  typedef struct packed {
    logic       m;
    logic [7:0] d;
  } rd_t;
  rd_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are set at posedge+1; grants are checked mid-cycle, read returns after the edge.
  task automatic step(input logic eg0, input logic eg1);
    rd_t e;
    #4;
    chk("m0_gnt", 32'(bus.m0_gnt), 32'(eg0));
    chk("m1_gnt", 32'(bus.m1_gnt), 32'(eg1));
    if (eg0) begin
      chk("mem_addr_m0", 32'(bus.mem_addr), 32'(bus.m0_addr));
      chk("mem_we_m0", 32'(bus.mem_we), 32'(bus.m0_we));
      if (bus.m0_we) begin
        chk("mem_wdata_m0", 32'(bus.mem_wdata), 32'(bus.m0_wdata));
        ref_mem[bus.m0_addr] = bus.m0_wdata;
      end else
        sb.push_back(rd_t'{m: 1'b0, d: ref_mem[bus.m0_addr]});
    end else if (eg1) begin
      chk("mem_addr_m1", 32'(bus.mem_addr), 32'(bus.m1_addr));
      chk("mem_we_m1", 32'(bus.mem_we), 32'(bus.m1_we));
      if (bus.m1_we) begin
        chk("mem_wdata_m1", 32'(bus.mem_wdata), 32'(bus.m1_wdata));
        ref_mem[bus.m1_addr] = bus.m1_wdata;
      end else
        sb.push_back(rd_t'{m: 1'b1, d: ref_mem[bus.m1_addr]});
    end else begin
      chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
      chk("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(!e.m));
      chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(e.m));
      chk("rdata", 32'(bus.rdata), 32'(e.d));
    end else begin
      chk("m0_rvalid_idle", 32'(bus.m0_rvalid), 32'd0);
      chk("m1_rvalid_idle", 32'(bus.m1_rvalid), 32'd0);
    end
  endtask

  task automatic m0_drive(input logic req, input logic we, input logic [7:0] a,
                          input logic [7:0] d, input logic lk);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_lock = lk;
  endtask

  task automatic m1_drive(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    ram[8'h10]     = 8'h5A;
    ref_mem[8'h10] = 8'h5A;
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state, including grants held low while requests are present.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    m0_drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    m1_drive(1'b1, 1'b1, 8'h12, 8'h23);
    #1;
    chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: single CPU read
    m0_drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    step(1'b1, 1'b0);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0);

    // 2: continuous contention, master 1 forced every fifth cycle
    m0_drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    m1_drive(1'b1, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 10; i++)
      step(!((i % 5) == 4), (i % 5) == 4);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);

    // 3: locked CPU write burst with an idle locked cycle, master 1 waiting
    m1_drive(1'b1, 1'b0, 8'h50, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b0, 1'b0);
      end
      m0_drive(1'b1, 1'b1, 8'h20 + 8'(i), 8'h80 + 8'(i), 1'b1);
      step(1'b1, 1'b0);
    end
    chk("lock_wait_cnt_sat", 32'(bus.wait_cnt), 32'(MAX_WAIT));
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);
    m0_drive(1'b1, 1'b0, 8'h27, 8'h00, 1'b0);
    step(1'b1, 1'b0);

    // 3b: unlock while the CPU keeps requesting; force applies one cycle later
    m1_drive(1'b1, 1'b0, 8'h51, 8'h00);
    for (int i = 0; i < 5; i++) begin
      m0_drive(1'b1, 1'b1, 8'h70 + 8'(i), 8'h90 + 8'(i), 1'b1);
      step(1'b1, 1'b0);
    end
    m0_drive(1'b1, 1'b1, 8'h75, 8'h95, 1'b0);
    step(1'b1, 1'b0);
    m0_drive(1'b1, 1'b1, 8'h76, 8'h96, 1'b0);
    step(1'b0, 1'b1);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // 4: master 1 write, then CPU read of the same location
    m1_drive(1'b1, 1'b1, 8'h40, 8'h33);
    step(1'b0, 1'b1);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);
    m0_drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
    step(1'b1, 1'b0);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // 6: simultaneous read/write to one address
    m0_drive(1'b1, 1'b0, 8'h60, 8'h00, 1'b0);
    m1_drive(1'b1, 1'b1, 8'h60, 8'hC3);
    step(1'b1, 1'b0);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);
    m0_drive(1'b1, 1'b0, 8'h60, 8'h00, 1'b0);
    step(1'b1, 1'b0);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0);

    // 5: reset right behind a master 1 read grant drops the read
    m1_drive(1'b1, 1'b0, 8'h10, 8'h00);
    #4;
    chk("pre_rst_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    rst = 1'b0;
    m0_drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("rst5_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    chk("rst5_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("rst5_rdata", 32'(bus.rdata), 32'd0);
    chk("rst5_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    chk("rst5_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("rst5_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    chk("rst5_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst5_mem_addr", 32'(bus.mem_addr), 32'd0);
    m0_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    m1_drive(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    step(1'b0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
